// File: rtl/sat_pkg.sv
// Shared SAT-engine definitions: the null literal value and the temporal buffer reader state encoding.
package sat_pkg;

    localparam int NULL_LITERAL = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_STREAM,
        S_DONE
    } reader_state_t;

endpackage

// File: rtl/next_literal_finder.sv
// Finds the first eligible literal slot strictly above i_k in a packed literal vector.
// With TB_READER_SKIP_NULL_EN defined, null slots are not eligible; otherwise every slot is.
module next_literal_finder
    import sat_pkg::*;
#(
    parameter int NLIT  = 40,
    parameter int LAW   = 12,
    parameter int CNT_W = 6
) (
    input  logic [NLIT*LAW-1:0] i_vec,
    input  logic [CNT_W-1:0]    i_k,
    output logic [CNT_W-1:0]    o_next,
    output logic                o_found
);

`ifdef TB_READER_SKIP_NULL_EN
    // Descending scan so the lowest qualifying slot is the one left standing.
    always_comb begin
        o_found = 1'b0;
        o_next  = '0;
        for (int i = NLIT - 1; i >= 0; i--) begin
            if ((CNT_W'(i) > i_k) && (i_vec[i*LAW +: LAW] != LAW'(NULL_LITERAL))) begin
                o_found = 1'b1;
                o_next  = CNT_W'(i);
            end
        end
    end
`else
    logic [CNT_W:0] w_inc;
    logic           w_unused_vec;

    assign w_inc        = {1'b0, i_k} + (CNT_W+1)'(1);
    assign o_next       = w_inc[CNT_W-1:0];
    assign o_found      = (w_inc < (CNT_W+1)'(NLIT));
    assign w_unused_vec = ^i_vec;
`endif

endmodule

// File: rtl/temporal_buffer_reader.sv
// Read-side sequencer: selects a temporal buffer entry, shadows its literal vector and streams it.
// Optional macro TB_READER_SKIP_NULL_EN: skip null literals instead of streaming every slot.
module temporal_buffer_reader
    import sat_pkg::*;
#(
    parameter  int NSAT                  = 3,
    parameter  int LITERAL_ADDRESS_WIDTH = 12,
    parameter  int MAX_CLAUSE_MEMBERSHIP = 20,
    parameter  int RD_LATENCY            = 1,
    localparam int NSAT_BITS             = $clog2(NSAT),
    localparam int LAW                   = LITERAL_ADDRESS_WIDTH,
    localparam int NLIT                  = (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP,
    localparam int CNT_W                 = $clog2(NLIT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NSAT_BITS-1:0] sel_index_i,
    output logic                 busy_o,
    output logic [NSAT_BITS-1:0] rd_index_o,
    input  logic [NLIT*LAW-1:0]  literals_mi,
    output logic                 lit_valid_o,
    input  logic                 lit_ready_i,
    output logic [LAW-1:0]       lit_o,
    output logic [CNT_W-1:0]     lit_idx_o,
    output logic                 lit_last_o,
    output logic                 done_o
);

    localparam int              LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    reader_state_t        r_state;
    reader_state_t        w_state_nxt;
    logic [LAT_W-1:0]     r_lat_cnt;
    logic [LAT_W-1:0]     w_lat_nxt;
    logic [NSAT_BITS-1:0] r_rd_index;
    logic [NSAT_BITS-1:0] w_rd_nxt;
    logic [CNT_W-1:0]     r_k;
    logic [CNT_W-1:0]     w_k_nxt;
    logic [NLIT*LAW-1:0]  r_shadow;
    logic                 w_capture;
    logic [NLIT*LAW-1:0]  w_fin_vec;
    logic [CNT_W-1:0]     w_fin_k;
    logic [CNT_W-1:0]     w_fin_next;
    logic                 w_fin_found;
    logic                 w_first_elig;
    logic                 w_streaming;

    // In LOAD the search runs on the live buffer output, since the shadow is only being filled.
    assign w_fin_vec = (r_state == S_LOAD) ? literals_mi : r_shadow;
    assign w_fin_k   = (r_state == S_LOAD) ? '0 : r_k;

`ifdef TB_READER_SKIP_NULL_EN
    assign w_first_elig = (literals_mi[LAW-1:0] != LAW'(NULL_LITERAL));
`else
    assign w_first_elig = 1'b1;
`endif

    next_literal_finder #(
        .NLIT  (NLIT),
        .LAW   (LAW),
        .CNT_W (CNT_W)
    ) u_finder (
        .i_vec   (w_fin_vec),
        .i_k     (w_fin_k),
        .o_next  (w_fin_next),
        .o_found (w_fin_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat_cnt;
        w_rd_nxt    = r_rd_index;
        w_k_nxt     = r_k;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_rd_nxt    = sel_index_i;
                    w_lat_nxt   = LAT_LOAD;
                    w_state_nxt = (RD_LATENCY == 0) ? S_LOAD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_lat_nxt = r_lat_cnt - LAT_W'(1);
                end
            end
            S_LOAD: begin
                w_capture = 1'b1;
                if (w_first_elig) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_STREAM;
                end else if (w_fin_found) begin
                    w_k_nxt     = w_fin_next;
                    w_state_nxt = S_STREAM;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_STREAM: begin
                if (lit_ready_i) begin
                    if (w_fin_found) begin
                        w_k_nxt = w_fin_next;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_lat_cnt  <= '0;
            r_rd_index <= '0;
            r_k        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat_cnt  <= w_lat_nxt;
            r_rd_index <= w_rd_nxt;
            r_k        <= w_k_nxt;
        end
    end

    // Shadow copy decouples the stream from later buffer rewrites; it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_shadow <= literals_mi;
        end
    end

    assign w_streaming = (r_state == S_STREAM);
    assign busy_o      = (r_state == S_WAIT) || (r_state == S_LOAD) || w_streaming;
    assign rd_index_o  = r_rd_index;
    assign lit_valid_o = w_streaming;
    assign lit_o       = w_streaming ? r_shadow[r_k*LAW +: LAW] : '0;
    assign lit_idx_o   = w_streaming ? r_k : '0;
    assign lit_last_o  = w_streaming && !w_fin_found;
    assign done_o      = (r_state == S_DONE);

endmodule
